// File: rtl/axis_pkg.sv
// Shared encodings for the AXI4-Stream pattern generator.
// Modes, FSM states and the LFSR feedback taps.
package axis_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_WALK  = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/axis_pattern_generator_lfsr32.sv
// 32-bit Fibonacci LFSR used by the pattern generator.
// Shifts left, feedback enters at bit 0; a zero seed loads as 1.
module lfsr32
    import axis_pkg::*;
(
    input  logic        clk_i,
    input  logic        s_rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] r_state;
    logic        w_fb;

    assign w_fb    = ^(r_state & LFSR_TAPS);
    assign state_o = r_state;

    // load takes priority over stepping; zero state would lock up
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_state <= '0;
        end else if (load_i) begin
            r_state <= (seed_i == '0) ? 32'd1 : seed_i;
        end else if (step_i) begin
            r_state <= {r_state[30:0], w_fb};
        end
    end

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream master emitting counter / LFSR / constant / walking-one
// packets of a configurable length, for a given or unbounded count.
module axis_pattern_generator
    import axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter logic [AXIS_DATA_WIDTH/8-1:0] AXIS_TKEEP = '1,
    parameter int LEN_WIDTH = 16,
    parameter int NUM_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         s_rst_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic [1:0]                   mode_i,
    input  logic [LEN_WIDTH-1:0]         pack_len_i,
    input  logic [NUM_WIDTH-1:0]         pack_num_i,
    input  logic [AXIS_DATA_WIDTH-1:0]   seed_i,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                         m_axis_tvalid_o,
    output logic                         m_axis_tlast_o,
    input  logic                         m_axis_tready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NUM_WIDTH-1:0]         pack_cnt_o
);

    localparam int W  = AXIS_DATA_WIDTH;
    localparam int SW = (W < 32) ? W : 32;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] WALK_INIT = {{(W-1){1'b0}}, 1'b1};

    state_t               r_state;
    mode_t                r_mode;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_beat;
    logic [NUM_WIDTH-1:0] r_num;
    logic [NUM_WIDTH-1:0] r_cnt;
    logic [W-1:0]         r_data;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_stop;

    logic                 w_hs;
    logic                 w_start;
    logic                 w_end;
    logic [LEN_WIDTH-1:0] w_len_in;
    logic [LEN_WIDTH-1:0] w_len_m1;
    logic [LEN_WIDTH-1:0] w_beat_nxt;
    logic [NUM_WIDTH-1:0] w_cnt_nxt;
    logic [31:0]          w_seed32;
    logic [31:0]          w_lfsr_state;
    logic [W-1:0]         w_lfsr_data;

    assign w_hs       = r_valid & m_axis_tready_i;
    assign w_start    = (r_state == ST_IDLE) & start_i;
    assign w_len_in   = (pack_len_i == '0) ? LEN_ONE : pack_len_i;
    assign w_len_m1   = r_len - LEN_ONE;
    assign w_beat_nxt = r_beat + LEN_ONE;
    assign w_cnt_nxt  = r_cnt + {{(NUM_WIDTH-1){1'b0}}, 1'b1};
    assign w_end      = ((r_num != '0) && (w_cnt_nxt == r_num))
                        | r_stop | stop_i;

    // low 32 seed bits feed the LFSR, zero-extended for narrow buses
    always_comb begin
        w_seed32 = '0;
        for (int i = 0; i < SW; i++) begin
            w_seed32[i] = seed_i[i];
        end
    end

    // LFSR state replicated across the full data width
    always_comb begin
        w_lfsr_data = '0;
        for (int i = 0; i < W; i++) begin
            w_lfsr_data[i] = w_lfsr_state[i[4:0]];
        end
    end

    lfsr32 u_lfsr (
        .clk_i   (clk_i),
        .s_rst_i (s_rst_i),
        .load_i  (w_start),
        .step_i  (w_hs && (r_mode == MODE_LFSR)),
        .seed_i  (w_seed32),
        .state_o (w_lfsr_state)
    );

    assign m_axis_tdata_o  = (r_mode == MODE_LFSR) ? w_lfsr_data : r_data;
    assign m_axis_tkeep_o  = r_valid ? AXIS_TKEEP : '0;
    assign m_axis_tvalid_o = r_valid;
    assign m_axis_tlast_o  = r_last;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign pack_cnt_o      = r_cnt;

    // run control: latch config on start, advance beats on handshake
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_CNT;
            r_len   <= '0;
            r_beat  <= '0;
            r_num   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode_t'(mode_i);
                        r_len   <= w_len_in;
                        r_num   <= pack_num_i;
                        r_cnt   <= '0;
                        r_beat  <= '0;
                        r_stop  <= 1'b0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (w_len_in == LEN_ONE);
                        r_data  <= (mode_t'(mode_i) == MODE_WALK) ?
                                   WALK_INIT : seed_i;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        r_stop <= 1'b1;
                    end
                    if (w_hs) begin
                        unique case (r_mode)
                            MODE_CNT:  r_data <= r_data + WALK_INIT;
                            MODE_WALK: r_data <= {r_data[W-2:0], r_data[W-1]};
                            default:   r_data <= r_data;
                        endcase
                        if (r_last) begin
                            r_cnt  <= w_cnt_nxt;
                            r_beat <= '0;
                            r_last <= (r_len == LEN_ONE);
                            if (w_end) begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_stop  <= 1'b0;
                            end
                        end else begin
                            r_beat <= w_beat_nxt;
                            r_last <= (w_beat_nxt == w_len_m1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_pattern_generator.md
AXIS_PATTERN_GENERATOR -- requirements
Module: axis_pattern_generator

Interface
REQ-001 The block SHALL have parameter AXIS_DATA_WIDTH, default 32, meaning the tdata width; legal values are multiples of 8 from 8 to 1024.
REQ-002 The block SHALL have parameter AXIS_TKEEP, default all-ones of AXIS_DATA_WIDTH/8 bits, meaning the constant value driven on tkeep.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 16, meaning the width of the beats-per-packet field.
REQ-004 The block SHALL have parameter NUM_WIDTH, default 16, meaning the width of the packet-count field.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port s_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port start_i, input, 1 bit: level-sampled start request.
REQ-008 The block SHALL have port stop_i, input, 1 bit: request to stop at the next packet boundary.
REQ-009 The block SHALL have port mode_i, input, 2 bits: pattern select (0 counter, 1 LFSR, 2 constant, 3 walking-one).
REQ-010 The block SHALL have port pack_len_i, input, LEN_WIDTH bits: beats per packet.
REQ-011 The block SHALL have port pack_num_i, input, NUM_WIDTH bits: packets per run; 0 means continuous.
REQ-012 The block SHALL have port seed_i, input, AXIS_DATA_WIDTH bits: initial pattern value.
REQ-013 The block SHALL have outputs m_axis_tdata_o (AXIS_DATA_WIDTH), m_axis_tkeep_o (AXIS_DATA_WIDTH/8), m_axis_tvalid_o (1) and m_axis_tlast_o (1), plus input m_axis_tready_i (1), forming the AXI4-Stream master.
REQ-014 The block SHALL have status outputs busy_o (1, high while running), done_o (1, one-cycle end-of-run pulse) and pack_cnt_o (NUM_WIDTH, number of completed packets).

Function
REQ-015 The FSM SHALL have the states IDLE and RUN; a handshake is defined as tvalid and tready both high on a clock edge.
REQ-016 In IDLE with start_i=1, the block SHALL latch mode_i, pack_len_i, pack_num_i and seed_i, clear pack_cnt_o, and enter RUN; tvalid rises in the next cycle.
REQ-017 start_i SHALL be ignored while in RUN; configuration input changes during RUN SHALL have no effect.
REQ-018 A latched pack_len of 0 SHALL be treated as 1.
REQ-019 In RUN, tvalid SHALL be 1; tdata and tlast SHALL change only in the cycle after a handshake (AXIS stability rule).
REQ-020 tlast SHALL be 1 exactly on the beat whose index within the packet equals pack_len-1.
REQ-021 On the tlast handshake, pack_cnt_o SHALL increment, and the beat index SHALL return to 0.
REQ-022 The run SHALL end on the tlast handshake when pack_cnt reaches pack_num (pack_num≠0) or a stop is pending; in the following cycle the state is IDLE, tvalid=0 and done_o=1 for one cycle.
REQ-023 A stop_i pulse in RUN SHALL set a sticky stop-pending flag; the current packet SHALL complete, with no truncation.
REQ-024 A stop_i pulse in IDLE SHALL be ignored; the flag SHALL clear on entry to RUN.
REQ-025 If stop_i and the tlast handshake occur in the same cycle, the run SHALL end after that packet.
REQ-026 In counter mode, the first beat SHALL equal seed, and tdata SHALL increment by 1 modulo 2^AXIS_DATA_WIDTH per handshake, continuing across packets and wrapping from all-ones to 0.
REQ-027 In LFSR mode, the block SHALL use a 32-bit Fibonacci LFSR with taps x^32+x^22+x^2+x+1, seeded from seed_i[31:0], with a seed of 0 replaced by 1; the LFSR SHALL step once per handshake, and tdata SHALL be the state replicated/truncated to AXIS_DATA_WIDTH.
REQ-028 In constant mode, tdata SHALL equal seed on every beat.
REQ-029 In walking-one mode, the first beat SHALL be 1 (bit 0 set) and SHALL rotate left by one bit per handshake, wrapping from the MSB to bit 0.
REQ-030 tkeep SHALL always equal AXIS_TKEEP while tvalid=1.
REQ-031 In continuous mode (pack_num=0), pack_cnt_o SHALL wrap modulo 2^NUM_WIDTH, and the run SHALL end only via stop.

Reset
REQ-032 s_rst_i=1 at a clock edge SHALL force IDLE and set tvalid, tlast, tdata, busy_o, done_o, pack_cnt_o, the stop flag, the beat index and the pattern registers to 0, overriding all other inputs, including mid-packet.
REQ-033 After reset is deasserted, the block SHALL stay in IDLE until start_i is sampled high.

Structure
REQ-034 The shared package axis_pkg SHALL hold the mode encodings (MODE_CNT, MODE_LFSR, MODE_CONST, MODE_WALK), the FSM state encodings and the LFSR tap constant.
REQ-035 One sub-module, lfsr32 (with step enable, load and seed), SHALL implement the LFSR; all other logic stays in the top module.

Verification
REQ-036 A bench SHALL check: W=32, counter mode, seed=0xFFFFFFFE, len=4, num=2, tready=1 -> data FFFFFFFE, FFFFFFFF, 0, 1, 2, 3, 4, 5; tlast on beats 4 and 8; done_o one cycle after beat 8; pack_cnt_o=2.
REQ-037 A bench SHALL check: random tready (50%), len=1024, num=1024 -> every held beat is stable while tready=0; exactly 1024 tlast; data is a gapless sequence.
REQ-038 A bench SHALL check: continuous mode, stop_i asserted at beat 3 of len=8 -> packet completes through tlast, then tvalid=0 and done_o=1.
REQ-039 A bench SHALL check: LFSR mode, seed=0 -> first beat 0x00000001, with the following beats matching the reference model; walking-one mode, W=8 -> 01, 02, …, 80, 01.
REQ-040 A bench SHALL check: s_rst_i asserted mid-packet -> all outputs 0 next cycle; a new start_i gives a fresh run from seed.
REQ-041 A bench SHALL check: len=0 -> every beat has tlast=1; start_i held during RUN -> no restart.
